// File: rtl/mf_fifo_pkg.sv
// rtl/mf_fifo_pkg.sv - shared defaults and tag-width helper for multi_flux_fifo
package mf_fifo_pkg;

    localparam int DEF_FLUX       = 2;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 8;

    // A single flux needs no tag bits at all.
    function automatic int tag_width(input int flux);
        return (flux > 1) ? $clog2(flux) : 0;
    endfunction

endpackage

// File: rtl/flux_queue.sv
// rtl/flux_queue.sv - single circular queue with occupancy count, flags and head output
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   wr_en, wr_data    accepted write (already gated by full in the parent)
//   rd_en             accepted read (already gated by empty in the parent)
//   head              entry at the read pointer
//   full, empty       derived from the registered count
module flux_queue
    import mf_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the cleared pointers make old contents unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem[wr_ptr] <= wr_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/multi_flux_fifo.sv
// rtl/multi_flux_fifo.sv - FLUX independent queues sharing one tagged write port
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   write, din   write strobe and {invalid, tag, payload}
//   full         per-queue full flags (registered)
//   read         per-queue read strobes, at most one set
//   empty        per-queue empty flags (registered)
//   dout         head payload of the queue being read
//   err          sticky protocol-error flag
module multi_flux_fifo
    import mf_fifo_pkg::*;
#(
    parameter int  FLUX       = DEF_FLUX,
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  DEPTH      = DEF_DEPTH,
    localparam int TAG_WIDTH  = tag_width(FLUX),
    localparam int DIN_WIDTH  = DATA_WIDTH + TAG_WIDTH + 1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write,
    input  logic [DIN_WIDTH-1:0]  din,
    output logic [FLUX-1:0]       full,
    input  logic [FLUX-1:0]       read,
    output logic [FLUX-1:0]       empty,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  err
);

    localparam int TW = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;

    logic                  invalid;
    logic [TW-1:0]         tag;
    logic                  tag_ok;
    logic                  wr_req;
    logic                  wr_reject;
    logic                  multi_rd;
    logic                  rd_reject;
    logic [FLUX-1:0]       wr_en;
    logic [FLUX-1:0]       rd_en;
    logic [FLUX-1:0]       full_q;
    logic [FLUX-1:0]       empty_q;
    logic [DATA_WIDTH-1:0] head [FLUX];

    assign invalid = din[DIN_WIDTH-1];

    generate
        if (TAG_WIDTH == 0) begin : g_no_tag
            assign tag = '0;
        end else begin : g_tag
            assign tag = din[DATA_WIDTH +: TAG_WIDTH];
        end
    endgenerate

    assign tag_ok = (32'(tag) < FLUX);
    // The invalid bit marks an idle slot, not a protocol error.
    assign wr_req = write & ~invalid;

    always_comb begin
        wr_reject = wr_req & ~tag_ok;
        for (int i = 0; i < FLUX; i++) begin
            wr_en[i] = wr_req && tag_ok && (tag == TW'(i)) && !full_q[i];
            if (wr_req && tag_ok && (tag == TW'(i)) && full_q[i]) wr_reject = 1'b1;
        end
    end

    // More than one strobe discards every read in that cycle.
    assign multi_rd  = ((read & (read - 1'b1)) != '0);
    assign rd_en     = multi_rd ? '0 : (read & ~empty_q);
    assign rd_reject = multi_rd | ((read & empty_q) != '0);

    always_ff @(posedge clk) begin
        if (!rst_n)                      err <= 1'b0;
        else if (wr_reject || rd_reject) err <= 1'b1;
    end

    generate
        for (genvar g = 0; g < FLUX; g++) begin : g_queue
            flux_queue #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH)
            ) u_queue (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (wr_en[g]),
                .wr_data (din[DATA_WIDTH-1:0]),
                .rd_en   (rd_en[g]),
                .head    (head[g]),
                .full    (full_q[g]),
                .empty   (empty_q[g])
            );
        end
    endgenerate

    // Downward scan so the lowest matching index wins.
    always_comb begin
        dout = '0;
        if (read != '0) begin
            for (int i = FLUX - 1; i >= 0; i--)
                if (read[i]) dout = head[i];
        end else begin
            for (int i = FLUX - 1; i >= 0; i--)
                if (!empty_q[i]) dout = head[i];
        end
    end

    assign full  = full_q;
    assign empty = empty_q;

endmodule
